// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type and prefix constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - ps2_clk synchronizer, glitch filter and falling-edge pulse
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        fall  <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decoding
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_extended,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic       clk_fall;
  logic       data_meta;
  logic       data_sync;
  ps2_state_e state;
  logic [3:0] bit_cnt;
  logic [TW-1:0] tcnt;
  logic [9:0] shreg;
  logic       ext_flag;
  logic       brk_flag;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_clk),
    .fall  (clk_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // tcnt is reloaded to 1 so it equals the cycles elapsed since the last fall pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      tcnt         <= '0;
      shreg        <= '0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      scan_code    <= 8'h00;
      key_valid    <= 1'b0;
      key_break    <= 1'b0;
      key_extended <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clk_fall && !data_sync) begin
            state   <= ST_RECV;
            bit_cnt <= '0;
            tcnt    <= TW'(1);
            shreg   <= '0;
          end
        end
        ST_RECV: begin
          if (clk_fall) begin
            shreg <= {data_sync, shreg[9:1]};
            tcnt  <= TW'(1);
            if (bit_cnt == 4'd9) begin
              state <= ST_CHECK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (tcnt == TO_LAST) begin
            frame_err <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            tcnt      <= '0;
            shreg     <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_CHECK: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          tcnt    <= '0;
          if (odd_parity_ok(shreg[8:0]) && shreg[9]) begin
            if (shreg[7:0] == PS2_EXT) begin
              ext_flag <= 1'b1;
            end else if (shreg[7:0] == PS2_BREAK) begin
              brk_flag <= 1'b1;
            end else begin
              key_valid    <= 1'b1;
              scan_code    <= shreg[7:0];
              key_break    <= brk_flag;
              key_extended <= ext_flag;
              ext_flag     <= 1'b0;
              brk_flag     <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a new ps2_clk level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle clk cycles within a frame before the frame is aborted (1 ms at 100 MHz).
REQ-003 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous, idle high.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous, idle high.
REQ-007 scan_code  output  8  last decoded non-prefix scan code, held until the next valid key.
REQ-008 key_valid  output  1  one-cycle pulse: scan_code, key_break and key_extended are updated.
REQ-009 key_break  output  1  the key event is a release (F0 prefix seen); held with scan_code.
REQ-010 key_extended  output  1  the key event carried an E0 prefix; held with scan_code.
REQ-011 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout failure.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-013 The filtered ps2_clk level SHALL change only after FILTER_LEN consecutive synchronized samples at the new level; shorter glitches SHALL be ignored.
REQ-014 A one-cycle fall pulse SHALL be generated on each 1->0 transition of the filtered clock; synchronized ps2_data SHALL be sampled in that cycle.
REQ-015 FSM states: IDLE, RECV, CHECK.
REQ-016 IDLE: fall pulse with data=0 (start bit) -> RECV with bit count 0; fall pulse with data=1 -> stay in IDLE, no error.
REQ-017 RECV: each fall pulse shifts in one bit, LSB first: 8 data bits, then parity, then stop; the 10th bit -> CHECK.
REQ-018 CHECK (one cycle): frame is good iff XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1; the FSM always returns to IDLE.
REQ-019 Good frame, byte 0xE0: set the extended flag; no key_valid.
REQ-020 Good frame, byte 0xF0: set the break flag; no key_valid.
REQ-021 Good frame, any other byte: key_valid pulses with scan_code = byte, key_break = break flag, key_extended = extended flag; both flags then clear.
REQ-022 key_valid SHALL assert exactly 2 clk cycles after the fall pulse of the stop bit.
REQ-023 Bad frame: frame_err pulses in the same cycle key_valid would have; both flags clear; scan_code, key_break and key_extended are held.
REQ-024 Timeout: in RECV, a counter reloads on every fall pulse; reaching TIMEOUT_CYCLES pulses frame_err, clears both flags, discards the partial byte and returns to IDLE.
REQ-025 key_valid and frame_err SHALL never assert in the same cycle.
REQ-026 Back-to-back frames with minimum PS/2 spacing SHALL decode without loss; CHECK completes before the next start bit can be sampled.

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE; bit count, timeout counter and shift register 0; flags clear; filtered clock 1; scan_code 0x00; key_valid, key_break, key_extended and frame_err 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no frame_err; the next complete frame after release decodes normally.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the FSM state type and the constants PS2_EXT=0xE0 and PS2_BREAK=0xF0.
REQ-030 Synchronizer, glitch filter and fall-edge detect SHALL be sub-module ps2_filter, instantiated for ps2_clk; ps2_data uses the synchronizer only.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> one key_valid pulse; scan_code=0x1C, key_break=0, key_extended=0; frame_err stays 0.
REQ-032 Frames F0, 1C -> exactly one key_valid pulse; scan_code=0x1C, key_break=1, key_extended=0.
REQ-033 Frames E0, F0, 75 -> one key_valid pulse, none for prefixes; scan_code=0x75, key_break=1, key_extended=1.
REQ-034 Frame 0x1C with parity bit 1 -> frame_err pulse, no key_valid; prior scan_code held.
REQ-035 Start bit plus 4 data bits, then idle -> frame_err exactly TIMEOUT_CYCLES after the 5th fall pulse; a following 0x2D frame -> key_valid with scan_code=0x2D.
REQ-036 A 3-cycle low glitch on ps2_clk mid-frame -> no extra bit shifted, frame decodes correctly; rst_n low for 1 cycle after bit 5 -> no output, next 0x1C frame decodes.
